// File: rtl/bist_pkg.sv
// Shared definitions for the memory BIST controller and its checkers.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  // True pattern pass followed by the inverted pattern pass.
  localparam int NUM_PASSES = 2;

  // Expected word for an address: seed plus address, inverted on the second
  // pass. Computed at 32 bits; callers keep the low DATA_WIDTH bits, which is
  // the same as the sum modulo 2**DATA_WIDTH.
  function automatic logic [31:0] bist_exp(input logic [31:0] seed,
                                           input logic [31:0] addr,
                                           input logic        p);
    logic [31:0] pat;
    pat = seed + addr;
    return p ? ~pat : pat;
  endfunction

endpackage

// File: rtl/mem_bist_top.sv
// Integration wrapper: BIST controller driving a reg_mem instance.
// Latency: identical to mem_bist_ctrl (4*N busy cycles on a clean run).
// Backpressure: none; start is ignored while busy.
module mem_bist_top #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_BITS-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got
);

  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_data_out;

  mem_bist_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wen      (mem_wen),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr),
    .fail_exp     (fail_exp),
    .fail_got     (fail_got)
  );

  reg_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk      (clk),
    .addr     (mem_addr),
    .data_in  (mem_data_in),
    .wen      (mem_wen),
    .data_out (mem_data_out)
  );

endmodule

// File: rtl/reg_mem.sv
// Single-port register-file memory: synchronous write, combinational read.
// Latency: write lands on the clock edge with wen=1; read data is same-cycle.
// Backpressure: none; accepts one access every cycle.
module reg_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // Write port: store data_in at addr on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[addr] <= data_in;
    end
  end

  assign data_out = mem[addr];

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: write-all/read-all with true then inverted pattern.
// Latency: clean run is busy 4*N cycles; done rises on the edge after that.
// Backpressure: none; start is ignored while busy, the memory never stalls.
module mem_bist_ctrl
  import bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_BITS-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got
);

  localparam int unsigned          DEPTH     = 2**ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(DEPTH - 1);

  bist_state_t           state_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  p_q;
  logic [ADDR_BITS-1:0]  addr_nxt;
  logic [DATA_WIDTH-1:0] exp_cur;
  logic [DATA_WIDTH-1:0] exp_nxt;

  // mem_addr is the address counter itself, so the compare word and the next
  // write word both come straight from registered state.
  assign addr_nxt = mem_addr + 1'b1;
  assign exp_cur  = DATA_WIDTH'(bist_exp(32'(seed_q), 32'(mem_addr), p_q));
  assign exp_nxt  = DATA_WIDTH'(bist_exp(32'(seed_q), 32'(addr_nxt), p_q));

  // Sequencer: walks addresses, drives the memory port and records the first
  // miscompare. Every output is a flop so the read data never reaches a pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seed_q      <= '0;
      p_q         <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_wen     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      fail_exp    <= '0;
      fail_got    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            seed_q      <= seed;
            p_q         <= 1'b0;
            mem_addr    <= '0;
            // First write word uses the incoming seed since seed_q is not
            // loaded until this edge.
            mem_data_in <= DATA_WIDTH'(bist_exp(32'(seed), 32'd0, 1'b0));
            mem_wen     <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_exp    <= '0;
            fail_got    <= '0;
            state_q     <= WRITE;
          end
        end

        WRITE: begin
          if (mem_addr == ADDR_LAST) begin
            mem_addr    <= '0;
            mem_wen     <= 1'b0;
            mem_data_in <= '0;
            state_q     <= READ;
          end else begin
            mem_addr    <= addr_nxt;
            mem_data_in <= exp_nxt;
          end
        end

        READ: begin
          if (mem_data_out != exp_cur) begin
            // Stop on the first error; mem_addr keeps the failing address.
            fail_addr <= mem_addr;
            fail_exp  <= exp_cur;
            fail_got  <= mem_data_out;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= DONE;
          end else if (mem_addr == ADDR_LAST) begin
            if (p_q == 1'(NUM_PASSES - 1)) begin
              pass    <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= DONE;
            end else begin
              p_q         <= 1'b1;
              mem_addr    <= '0;
              mem_wen     <= 1'b1;
              mem_data_in <= DATA_WIDTH'(bist_exp(32'(seed_q), 32'd0, 1'b1));
              state_q     <= WRITE;
            end
          end else begin
            mem_addr <= addr_nxt;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl against a fault-injectable memory model, with a
// mem_bist_top instance alongside for the clean-memory runs.
// Write traffic is checked by a scoreboard queue; results by per-test tasks.
module tb_mem_bist_ctrl;
  import bist_pkg::*;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] seed;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_wen;
  logic [7:0] mem_data_out;
  logic       busy, done, pass;
  logic [4:0] fail_addr;
  logic [7:0] fail_exp, fail_got;

  logic       top_busy, top_done, top_pass;
  logic [4:0] top_fail_addr;
  logic [7:0] top_fail_exp, top_fail_got;

  // memory model with an optional stuck-at-0 read fault
  logic [7:0] tb_mem [0:31];
  logic       fault_on;
  logic [4:0] fault_addr;
  logic [7:0] fault_mask;

  int   total;
  int   bad;
  int   busy_cnt;
  int   wr_cnt;
  logic [7:0] wr_log [0:63];
  wr_t  sb_q [$];
  wr_t  sb_e;

  mem_bist_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(5)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wen      (mem_wen),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr),
    .fail_exp     (fail_exp),
    .fail_got     (fail_got)
  );

  mem_bist_top #(.DATA_WIDTH(8), .ADDR_BITS(5)) u_top (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .busy      (top_busy),
    .done      (top_done),
    .pass      (top_pass),
    .fail_addr (top_fail_addr),
    .fail_exp  (top_fail_exp),
    .fail_got  (top_fail_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model write port
  always @(posedge clk) begin
    if (mem_wen === 1'b1) tb_mem[mem_addr] <= mem_data_in;
  end

  assign mem_data_out = tb_mem[mem_addr] &
                        ~((fault_on && (mem_addr == fault_addr)) ? fault_mask : 8'h00);

  // monitor: count busy cycles, log writes and pop the scoreboard per write
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (mem_wen === 1'b1) begin
      if (wr_cnt < 64) wr_log[wr_cnt] = mem_data_in;
      wr_cnt++;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, want no write", mem_addr, mem_data_in);
      end else begin
        sb_e = sb_q.pop_front();
        if ({mem_addr, mem_data_in} !== sb_e) begin
          bad++;
          $display("FAIL wr_data: got addr=%0d data=%h, want addr=%0d data=%h",
                   mem_addr, mem_data_in, sb_e.addr, sb_e.data);
        end
      end
    end
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic push_writes(input logic [7:0] s, input int npass);
    wr_t w;
    for (int p = 0; p < npass; p++) begin
      for (int a = 0; a < 32; a++) begin
        w.addr = 5'(a);
        w.data = 8'(bist_exp(32'(s), 32'(a), p[0]));
        sb_q.push_back(w);
      end
    end
  endtask

  // starts a run, optionally re-pulses start with another seed at cycle inj,
  // and waits for done; cyc counts edges from the start-sampling edge
  task automatic do_run(input logic [7:0] s, input int npass, input int inj, output int cyc);
    push_writes(s, npass);
    busy_cnt = 0;
    wr_cnt   = 0;
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      if (cyc == inj) begin
        start = 1'b1;
        seed  = ~s;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout: got done=%b after %0d cycles, want 1", done, cyc);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL wr_missing: got %0d expected writes left, want 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; seed = 8'h00;
    fault_on = 1'b0; fault_addr = 5'd0; fault_mask = 8'h00;
    #12;
    total++;
    if ({mem_wen, busy, done, pass} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctl: got wen/busy/done/pass=%b, want 0000", {mem_wen, busy, done, pass});
    end
    total++;
    if ({mem_addr, mem_data_in, fail_addr, fail_exp, fail_got} !== 34'd0) begin
      bad++;
      $display("FAIL reset_dat: got %h, want 0", {mem_addr, mem_data_in, fail_addr, fail_exp, fail_got});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_seed10();
    int cyc;
    do_run(8'd10, 2, 0, cyc);
    total++;
    if (wr_log[0] !== 8'd10 || wr_log[31] !== 8'd41 || wr_log[32] !== 8'hF5) begin
      bad++;
      $display("FAIL seed10_words: got a0=%h a31=%h inv_a0=%h, want 0a 29 f5", wr_log[0], wr_log[31], wr_log[32]);
    end
    total++;
    if (pass !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL seed10_pass: got pass=%b busy=%b, want 1 0", pass, busy);
    end
    total++;
    if (cyc != 129) begin
      bad++;
      $display("FAIL seed10_latency: got done at %0d, want 129", cyc);
    end
    total++;
    if (busy_cnt != 128) begin
      bad++;
      $display("FAIL seed10_busy: got %0d busy cycles, want 128", busy_cnt);
    end
    total++;
    if (top_done !== 1'b1 || top_pass !== 1'b1 || top_busy !== 1'b0) begin
      bad++;
      $display("FAIL top_seed10: got done=%b pass=%b busy=%b, want 1 1 0", top_done, top_pass, top_busy);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    do_run(8'hF0, 2, 0, cyc);
    total++;
    if (wr_log[31] !== 8'h0F || wr_log[63] !== 8'hF0) begin
      bad++;
      $display("FAIL wrap_words: got p0_a31=%h p1_a31=%h, want 0f f0", wr_log[31], wr_log[63]);
    end
    total++;
    if (pass !== 1'b1 || top_pass !== 1'b1) begin
      bad++;
      $display("FAIL wrap_pass: got pass=%b top_pass=%b, want 1 1", pass, top_pass);
    end
  endtask

  task automatic test_fault_pass0();
    int cyc;
    fault_on = 1'b1; fault_addr = 5'd5; fault_mask = 8'h01;
    do_run(8'h00, 1, 0, cyc);
    fault_on = 1'b0;
    total++;
    if (pass !== 1'b0 || fail_addr !== 5'd5) begin
      bad++;
      $display("FAIL f0_result: got pass=%b addr=%0d, want 0 5", pass, fail_addr);
    end
    total++;
    if (fail_exp !== 8'h05 || fail_got !== 8'h04) begin
      bad++;
      $display("FAIL f0_data: got exp=%h got=%h, want 05 04", fail_exp, fail_got);
    end
    total++;
    if (busy_cnt != 38) begin
      bad++;
      $display("FAIL f0_busy: got %0d, want 38", busy_cnt);
    end
    total++;
    if (mem_wen !== 1'b0 || mem_addr !== 5'd5) begin
      bad++;
      $display("FAIL f0_hold: got wen=%b addr=%0d, want 0 5", mem_wen, mem_addr);
    end
  endtask

  task automatic test_fault_pass1();
    int cyc;
    fault_on = 1'b1; fault_addr = 5'd3; fault_mask = 8'h80;
    do_run(8'h00, 2, 0, cyc);
    fault_on = 1'b0;
    total++;
    if (pass !== 1'b0 || fail_addr !== 5'd3 || fail_exp !== 8'hFC || fail_got !== 8'h7C) begin
      bad++;
      $display("FAIL f1_result: got pass=%b addr=%0d exp=%h got=%h, want 0 3 fc 7c",
               pass, fail_addr, fail_exp, fail_got);
    end
    total++;
    if (busy_cnt != 100) begin
      bad++;
      $display("FAIL f1_busy: got %0d, want 100", busy_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    int cyc;
    push_writes(8'h33, 2);
    seed  = 8'h33;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(mem_wen === 1'b1 && mem_addr === 5'd12) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (mem_addr !== 5'd12 || mem_wen !== 1'b1) begin
      bad++;
      $display("FAIL rst_reach: got addr=%0d wen=%b, want 12 1", mem_addr, mem_wen);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_wen !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got wen=%b busy=%b, want 0 0", mem_wen, busy);
    end
    total++;
    if ({done, pass, mem_addr, mem_data_in, fail_addr, fail_exp, fail_got} !== 36'd0) begin
      bad++;
      $display("FAIL rst_outs: got %h, want 0", {done, pass, mem_addr, mem_data_in, fail_addr, fail_exp, fail_got});
    end
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_run(8'h33, 2, 0, cyc);
    total++;
    if (pass !== 1'b1 || busy_cnt != 128) begin
      bad++;
      $display("FAIL rst_rerun: got pass=%b busy=%0d, want 1 128", pass, busy_cnt);
    end
  endtask

  task automatic test_start_busy();
    int cyc;
    do_run(8'h5A, 2, 40, cyc);
    total++;
    if (busy_cnt != 128 || cyc != 129) begin
      bad++;
      $display("FAIL ign_timing: got busy=%0d done_at=%0d, want 128 129", busy_cnt, cyc);
    end
    total++;
    if (pass !== 1'b1) begin
      bad++;
      $display("FAIL ign_pass: got %b, want 1", pass);
    end
  endtask

  initial begin
    total = 0; bad = 0; busy_cnt = 0; wr_cnt = 0;
    test_reset();
    test_seed10();
    test_wrap();
    test_fault_pass0();
    test_fault_pass1();
    test_reset_midrun();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Built-in self-test sequencer sitting directly upstream of reg_mem; drives its addr/data_in/wen port and consumes its data_out.
- Runs two write-all/read-all passes: a true pattern, then an inverted pattern.
- Compares every read word against the expected value and reports pass/fail, including the first failing address and data.
- Replaces hand-written fill/readback loops in benches and gives silicon-level memory self-check.

Parameters:
- DATA_WIDTH, 8, word width; must match the reg_mem instance.
- ADDR_BITS, 5, address width; depth N = 2**ADDR_BITS.

Ports:
- clk  in  1  rising-edge clock shared with reg_mem
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a test run; sampled only in IDLE or DONE
- seed  in  DATA_WIDTH  pattern base; latched when start is accepted
- mem_addr  out  ADDR_BITS  to reg_mem addr
- mem_data_in  out  DATA_WIDTH  to reg_mem data_in
- mem_wen  out  1  to reg_mem wen
- mem_data_out  in  DATA_WIDTH  from reg_mem data_out
- busy  out  1  high during WRITE/READ
- done  out  1  level; high in DONE until the next accepted start
- pass  out  1  valid while done=1; 1 means no mismatch
- fail_addr  out  ADDR_BITS  address of first mismatch
- fail_exp  out  DATA_WIDTH  expected word at first mismatch
- fail_got  out  DATA_WIDTH  read word at first mismatch

Behaviour:
- Memory contract:
  - reg_mem writes on the rising edge of clk when wen=1.
  - Its read is combinational (data_out = mem[addr]).
  - The controller compares mem_data_out at the same rising edge that mem_addr is presented.
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including mem_wen. mem_wen drops immediately, not at the next edge.
- States: IDLE, WRITE, READ, DONE. Internal pass bit p is 0 or 1.
- Pattern:
  - pat(a) = (seed_q + a) mod 2**DATA_WIDTH.
  - Expected word exp(a) = pat(a) when p=0, ~pat(a) when p=1.
- IDLE or DONE with start=1:
  - Latch seed_q.
  - p←0, addr←0, clear done/pass/fail_*.
  - Go to WRITE; busy=1 from the next cycle.
- WRITE:
  - mem_wen=1, mem_data_in=exp(mem_addr). One address per cycle.
  - At addr N-1: addr wraps to 0, go to READ.
- READ:
  - mem_wen=0, mem_data_in=0.
  - Each cycle compare mem_data_out against exp(mem_addr).
  - On mismatch: capture fail_addr, fail_exp, fail_got; pass←0; go to DONE immediately (stop on first error).
  - At addr N-1 with no mismatch:
    - If p=0: p←1, addr←0, go to WRITE.
    - If p=1: pass←1, go to DONE.
- DONE:
  - busy=0, done=1.
  - mem_addr holds its last value; mem_wen=0.
- start while busy is ignored.
- Latency: a clean run is busy for exactly 4N cycles. done rises at edge 4N+1 after the start sample (129 cycles for N=32).
- All outputs are registered or derived only from registered state. There is no combinational path from mem_data_out to any output.
- Reset mid-run aborts the run. Memory contents are left undefined-by-test; the next start reruns from scratch.

Decomposition:
- Shared package bist_pkg holds:
  - state enum (IDLE, WRITE, READ, DONE)
  - NUM_PASSES=2
  - function bist_exp(seed, addr, p) returning the expected word. Shared by the RTL and the bench scoreboard.
- No sub-module is required; the address counter and FSM live in mem_bist_ctrl.
- Top-level integration wrapper mem_bist_top instantiates mem_bist_ctrl plus reg_mem #(DATA_WIDTH,ADDR_BITS).

Test Plan:
- mem_bist_top, seed=10, start pulse:
  - Writes addr0=10 … addr31=41, then the inverted pass addr0=0xF5.
  - pass=1; done rises 129 cycles after start.
- seed=0xF0:
  - pass-0 write at addr 31 is 0x0F (wrap); pass-1 write at addr 31 is 0xF0.
  - pass=1.
- Bench memory model with bit0 stuck-at-0 at addr 5, seed=0:
  - done, pass=0, fail_addr=5, fail_exp=0x05, fail_got=0x04.
  - busy lasts 32+6 cycles.
- Bench model with bit7 stuck-at-0 at addr 3, seed=0:
  - Pass 0 clean; failure occurs in pass 1.
  - fail_addr=3, fail_exp=0xFC, fail_got=0x7C.
- rst_n low during WRITE at addr 12:
  - mem_wen=0 and busy=0 before the next edge; all outputs 0.
  - After release, start completes with pass=1.
- start pulsed at cycle 40 of a run:
  - Ignored; total busy stays 128; seed change at that time has no effect on written data.
